// File: rtl/qq_arb.sv
// Round-robin arbiter in front of a single-port priority queue: one transaction in flight at a time.
// Optional build macro QQ_ARB_STATS_EN adds saturating command/error counters.
package pq_pkg;
  localparam int unsigned KEY_W = 8;
  localparam int unsigned VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam kv_t KV_EMPTY = '{key: {KEY_W{1'b1}}, val: {VAL_W{1'b0}}};
endpackage

module qq_arb
  import pq_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [2*NREQ-1:0] op_i,
  input  kv_t               kv_i [NREQ],
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   rsp_vld_o,
  output logic              rsp_err_o,
  output kv_t               rsp_kv_o,
  output logic              q_enq_o,
  output logic              q_deq_o,
  output logic              q_repl_o,
  output kv_t               q_kv_o,
  input  kv_t               q_kv_i,
  input  logic              q_full_i,
  input  logic              q_empty_i,
  input  logic              q_rdy_i,
  output logic              busy_o
`ifdef QQ_ARB_STATS_EN
  ,
  output logic [15:0]       stat_enq_o,
  output logic [15:0]       stat_deq_o,
  output logic [15:0]       stat_repl_o,
  output logic [15:0]       stat_err_o
`endif
);

  localparam int unsigned NW = $clog2(NREQ);
  localparam int unsigned CW = 3;
  localparam int unsigned SW = 16;

  localparam logic [1:0] OP_ILL  = 2'b00;
  localparam logic [1:0] OP_ENQ  = 2'b01;
  localparam logic [1:0] OP_DEQ  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [NW-1:0]   r_last;
  logic [NW-1:0]   r_idx;
  logic [1:0]      r_op;
  logic            r_err;
  logic [CW-1:0]   r_cnt;

  logic [NW-1:0]   w_win;
  logic [NW-1:0]   w_k;
  logic            w_found;
  logic [1:0]      w_op;
  kv_t             w_kv;
  logic            w_err;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_idx_oh;

  // Round-robin search starting just after the last-served requester
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_k     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_k = NW'((32'(r_last) + i) % NREQ);
      if (!w_found && req_i[w_k]) begin
        w_found = 1'b1;
        w_win   = w_k;
      end
    end
  end

  assign w_op     = op_i[{w_win, 1'b0} +: 2];
  assign w_kv     = kv_i[w_win];
  assign w_err    = (w_op == OP_ILL) | ((w_op == OP_ENQ) & q_full_i) | (w_op[1] & q_empty_i);
  assign w_win_oh = NREQ'(1) << w_win;
  assign w_idx_oh = NREQ'(1) << r_idx;

  // Queue status is judged at accept time so the command and the error verdict agree
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= NW'(NREQ - 1);
      r_idx     <= '0;
      r_op      <= OP_ILL;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      gnt_o     <= '0;
      rsp_vld_o <= '0;
      rsp_err_o <= 1'b0;
      rsp_kv_o  <= KV_EMPTY;
      q_enq_o   <= 1'b0;
      q_deq_o   <= 1'b0;
      q_repl_o  <= 1'b0;
      q_kv_o    <= KV_EMPTY;
      busy_o    <= 1'b0;
    end else begin
      gnt_o     <= '0;
      rsp_vld_o <= '0;
      q_enq_o   <= 1'b0;
      q_deq_o   <= 1'b0;
      q_repl_o  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found && q_rdy_i) begin
            r_idx   <= w_win;
            r_op    <= w_op;
            r_err   <= w_err;
            r_state <= ISSUE;
            busy_o  <= 1'b1;
            if (!w_err) begin
              gnt_o    <= w_win_oh;
              q_enq_o  <= (w_op == OP_ENQ);
              q_deq_o  <= (w_op == OP_DEQ);
              q_repl_o <= (w_op == OP_REPL);
              q_kv_o   <= (w_op == OP_DEQ) ? KV_EMPTY : w_kv;
            end
          end
        end
        ISSUE: begin
          if (r_err || (r_op == OP_ENQ)) begin
            r_state   <= RESP;
            rsp_vld_o <= w_idx_oh;
            rsp_err_o <= r_err;
            rsp_kv_o  <= KV_EMPTY;
          end else begin
            r_state <= WAIT;
            r_cnt   <= CW'(1);
          end
        end
        WAIT: begin
          if (r_cnt == CW'(RD_LAT)) begin
            r_state   <= RESP;
            rsp_vld_o <= w_idx_oh;
            rsp_err_o <= 1'b0;
            rsp_kv_o  <= q_kv_i;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          r_last  <= r_idx;
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef QQ_ARB_STATS_EN
  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_enq_o  <= '0;
      stat_deq_o  <= '0;
      stat_repl_o <= '0;
      stat_err_o  <= '0;
    end else begin
      if (q_enq_o && (stat_enq_o != '1))
        stat_enq_o <= stat_enq_o + SW'(1);
      if (q_deq_o && (stat_deq_o != '1))
        stat_deq_o <= stat_deq_o + SW'(1);
      if (q_repl_o && (stat_repl_o != '1))
        stat_repl_o <= stat_repl_o + SW'(1);
      if ((|rsp_vld_o) && rsp_err_o && (stat_err_o != '1))
        stat_err_o <= stat_err_o + SW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_qq_arb.sv
// Bench for qq_arb: transaction-level model of arbitration/latency plus a sorted-list queue
// emulation driving q_kv_i/q_full_i/q_empty_i; directed scenarios first, then random traffic.
module tb_qq_arb;
  import pq_pkg::*;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned CAP    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_i = '0;
  logic [2*NREQ-1:0] op_i = '0;
  kv_t               kv_i [NREQ];
  logic [NREQ-1:0]   gnt_o, rsp_vld_o;
  logic              rsp_err_o, q_enq_o, q_deq_o, q_repl_o, busy_o;
  kv_t               rsp_kv_o, q_kv_o;
  kv_t               q_kv_i = KV_EMPTY;
  logic              q_full_i = 1'b0, q_empty_i = 1'b1, q_rdy_i = 1'b1;
`ifdef QQ_ARB_STATS_EN
  logic [15:0]       stat_enq_o, stat_deq_o, stat_repl_o, stat_err_o;
`endif

  always #5 clk = ~clk;

  qq_arb #(.NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .kv_i(kv_i),
    .gnt_o(gnt_o), .rsp_vld_o(rsp_vld_o), .rsp_err_o(rsp_err_o), .rsp_kv_o(rsp_kv_o),
    .q_enq_o(q_enq_o), .q_deq_o(q_deq_o), .q_repl_o(q_repl_o), .q_kv_o(q_kv_o),
    .q_kv_i(q_kv_i), .q_full_i(q_full_i), .q_empty_i(q_empty_i), .q_rdy_i(q_rdy_i),
    .busy_o(busy_o)
`ifdef QQ_ARB_STATS_EN
    , .stat_enq_o(stat_enq_o), .stat_deq_o(stat_deq_o),
    .stat_repl_o(stat_repl_o), .stat_err_o(stat_err_o)
`endif
  );

  int errors = 0;
  int checks = 0;
  int n = 0;

  // Model: the single outstanding transaction, described by its accept/response cycles
  bit         m_act = 1'b0;
  int         m_acc, m_rsp, m_win;
  int         m_last = NREQ - 1;
  logic [1:0] m_op;
  kv_t        m_kv, m_rkv;
  bit         m_err;
  int         st_enq = 0, st_deq = 0, st_repl = 0, st_err = 0;

  // Queue emulation (ascending key order, head is the minimum)
  kv_t q_mem[$];
  int  pend_cyc = -100;
  kv_t pend_kv;
  int  gnt_log[$];

  function automatic kv_t mk(input int k, input int v);
    kv_t r;
    r.key = 8'(k);
    r.val = 8'(v);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic ins(input kv_t v);
    int p = 0;
    while (p < q_mem.size() && q_mem[p].key <= v.key) p++;
    q_mem.insert(p, v);
  endtask

  task automatic env_status();
    q_full_i  = (q_mem.size() >= CAP);
    q_empty_i = (q_mem.size() == 0);
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input kv_t kv);
    req_i[p]         = 1'b1;
    op_i[2*p +: 2]   = op;
    kv_i[p]          = kv;
  endtask

  task automatic model_accept();
    if ((!m_act || n > m_rsp) && (|req_i) && q_rdy_i) begin
      for (int k = 1; k <= int'(NREQ); k++) begin
        if (req_i[(m_last + k) % NREQ]) begin
          m_win = (m_last + k) % NREQ;
          break;
        end
      end
      m_op  = op_i[2*m_win +: 2];
      m_kv  = kv_i[m_win];
      m_err = (m_op == 2'b00) || (m_op == 2'b01 && q_full_i) || (m_op[1] && q_empty_i);
      m_rkv = KV_EMPTY;
      if (!m_err && m_op[1]) m_rkv = q_mem[0];
      m_acc  = n;
      m_rsp  = (m_err || m_op == 2'b01) ? n + 2 : n + 2 + int'(RD_LAT);
      m_act  = 1'b1;
      m_last = m_win;
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] oh;
    bit in_cmd, in_rsp;
    oh     = NREQ'(1) << m_win;
    in_cmd = m_act && (n == m_acc + 1) && !m_err;
    in_rsp = m_act && (n == m_rsp);
    chk("busy", 32'(busy_o), 32'(m_act && n > m_acc && n <= m_rsp));
    chk("gnt", 32'(gnt_o), in_cmd ? 32'(oh) : 32'd0);
    chk("q_enq", 32'(q_enq_o), 32'(in_cmd && m_op == 2'b01));
    chk("q_deq", 32'(q_deq_o), 32'(in_cmd && m_op == 2'b10));
    chk("q_repl", 32'(q_repl_o), 32'(in_cmd && m_op == 2'b11));
    if (in_cmd) chk("q_kv_o", 32'(q_kv_o), 32'((m_op == 2'b10) ? KV_EMPTY : m_kv));
    chk("rsp_vld", 32'(rsp_vld_o), in_rsp ? 32'(oh) : 32'd0);
    if (in_rsp) begin
      chk("rsp_err", 32'(rsp_err_o), 32'(m_err));
      chk("rsp_kv", 32'(rsp_kv_o), 32'(m_rkv));
    end
`ifdef QQ_ARB_STATS_EN
    chk("stat_enq", 32'(stat_enq_o), 32'(st_enq));
    chk("stat_deq", 32'(stat_deq_o), 32'(st_deq));
    chk("stat_repl", 32'(stat_repl_o), 32'(st_repl));
    chk("stat_err", 32'(stat_err_o), 32'(st_err));
`endif
    if (in_cmd && m_op == 2'b01) st_enq++;
    if (in_cmd && m_op == 2'b10) st_deq++;
    if (in_cmd && m_op == 2'b11) st_repl++;
    if (in_rsp && m_err) st_err++;
    for (int i = 0; i < int'(NREQ); i++) if (gnt_o[i]) gnt_log.push_back(i);
  endtask

  // Queue reacts to the commands the DUT actually issued
  task automatic env_update();
    if (q_enq_o) ins(q_kv_o);
    if (q_deq_o || q_repl_o) begin
      pend_kv  = (q_mem.size() > 0) ? q_mem.pop_front() : KV_EMPTY;
      pend_cyc = n + int'(RD_LAT);
    end
    if (q_repl_o) ins(q_kv_o);
    q_kv_i = (n == pend_cyc) ? pend_kv : kv_t'(16'($urandom));
    env_status();
  endtask

  task automatic cycle();
    model_accept();
    @(posedge clk);
    #1;
    n++;
    compare();
    env_update();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_cmds", 32'({q_enq_o, q_deq_o, q_repl_o}), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rsp_kv", 32'(rsp_kv_o), 32'h0000ff00);
    chk("rst_q_kv", 32'(q_kv_o), 32'h0000ff00);
    m_act = 1'b0; m_last = NREQ - 1; pend_cyc = -100;
    st_enq = 0; st_deq = 0; st_repl = 0; st_err = 0;
    req_i = '0; op_i = '0;
    @(posedge clk);
    #1;
    n++;
    rst = 1'b0;
    q_rdy_i = 1'b1;
    env_status();
  endtask

  initial begin
    int r, rsp_cnt;
    logic [1:0] op;
    for (int i = 0; i < int'(NREQ); i++) kv_i[i] = KV_EMPTY;
    @(posedge clk);
    #1;
    do_reset();

    // Single enq from port 0; requester drops req mid-transaction
    set_req(0, 2'b01, mk(5, 8'h55));
    cycle();
    chk("t1_enq", 32'(q_enq_o), 32'd1);
    chk("t1_kv", 32'(q_kv_o.key), 32'd5);
    req_i = '0; op_i = '0;
    cycle();
    chk("t1_vld", 32'(rsp_vld_o), 32'b0001);
    chk("t1_err", 32'(rsp_err_o), 32'd0);
    cycle();

    // Deq from port 1 with queue holding {3,7}
    q_mem.delete(); q_mem.push_back(mk(3, 1)); q_mem.push_back(mk(7, 2)); env_status();
    set_req(1, 2'b10, mk(99, 9));
    cycle();
    chk("t2_deq", 32'(q_deq_o), 32'd1);
    cycle();
    cycle();
    chk("t2_novld", 32'(rsp_vld_o), 32'd0);
    cycle();
    chk("t2_vld", 32'(rsp_vld_o), 32'b0010);
    chk("t2_key", 32'(rsp_kv_o.key), 32'd3);
    req_i = '0;
    cycle();

    // All four enq after reset: strict 0,1,2,3 order
    do_reset();
    q_mem.delete(); env_status();
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 2'b01, mk(10 + i, i));
    gnt_log.delete();
    rsp_cnt = 0;
    for (int c = 0; c < 40 && rsp_cnt < 4; c++) begin
      cycle();
      for (int i = 0; i < int'(NREQ); i++) if (rsp_vld_o[i]) begin req_i[i] = 1'b0; rsp_cnt++; end
    end
    chk("t3_rsp_cnt", 32'(rsp_cnt), 32'd4);
    chk("t3_gnt_cnt", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_order", 32'((i < gnt_log.size()) ? gnt_log[i] : -1), 32'(i));
    cycle();

    // Deq on empty queue from port 2 -> error, no command
    q_mem.delete(); env_status();
    set_req(2, 2'b10, mk(1, 1));
    cycle();
    chk("t4_nodeq", 32'(q_deq_o), 32'd0);
    chk("t4_nognt", 32'(gnt_o), 32'd0);
    cycle();
    chk("t4_vld", 32'(rsp_vld_o), 32'b0100);
    chk("t4_err", 32'(rsp_err_o), 32'd1);
    chk("t4_kv", 32'(rsp_kv_o), 32'h0000ff00);
    req_i = '0;
    cycle();

    // Reset during WAIT abandons the deq; port 0 then wins over port 3
    q_mem.delete(); q_mem.push_back(mk(9, 9)); env_status();
    set_req(2, 2'b10, mk(1, 1));
    cycle();
    cycle();
    chk("t5_in_wait", 32'(busy_o), 32'd1);
    do_reset();
    set_req(0, 2'b01, mk(20, 0));
    set_req(3, 2'b01, mk(21, 3));
    cycle();
    chk("t5_gnt", 32'(gnt_o), 32'b0001);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (rsp_vld_o[i]) req_i[i] = 1'b0;
        else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
          r  = int'($urandom_range(0, 15));
          op = (r == 0) ? 2'b00 : (r < 7) ? 2'b01 : (r < 12) ? 2'b10 : 2'b11;
          set_req(i, op, kv_t'(16'($urandom)));
        end
      end
      q_rdy_i = ($urandom_range(0, 4) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qq_arb.md
QQ_ARB -- requirements
Module: qq_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter RD_LAT, default 2, cycles from q_deq_o/q_repl_o pulse to valid q_kv_i (1..7).
REQ-003 SHALL have localparam NW = $clog2(NREQ), requester index width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_i  in  NREQ  per-requester request level.
REQ-007 SHALL have port op_i  in  2*NREQ  per-requester opcode: 01 enq, 10 deq, 11 repl, 00 illegal.
REQ-008 SHALL have port kv_i  in  NREQ x kv_t  per-requester key/value (pq_pkg).
REQ-009 SHALL have port gnt_o  out  NREQ  one-hot grant, one-cycle pulse at issue.
REQ-010 SHALL have port rsp_vld_o  out  NREQ  one-hot completion pulse.
REQ-011 SHALL have port rsp_err_o  out  1  error flag, qualified by rsp_vld_o.
REQ-012 SHALL have port rsp_kv_o  out  kv_t  returned key/value, qualified by rsp_vld_o.
REQ-013 SHALL have ports q_enq_o, q_deq_o, q_repl_o  out  1 each  queue command pulses.
REQ-014 SHALL have port q_kv_o  out  kv_t  data to queue left input.
REQ-015 SHALL have port q_kv_i  in  kv_t  data from queue left output.
REQ-016 SHALL have ports q_full_i, q_empty_i, q_rdy_i  in  1 each  queue status (full_t, empty_t, rdy_t).
REQ-017 SHALL have port busy_o  out  1  high whenever state != IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: when any req_i bit is set and q_rdy_i=1, SHALL select a winner round-robin (search starts at last-served index + 1, wrapping mod NREQ), latch index/op/kv, and go to ISSUE.
REQ-020 IDLE with q_rdy_i=0 SHALL remain in IDLE with no grant.
REQ-021 ISSUE: op enq with q_full_i=1, op deq/repl with q_empty_i=1, or op 00 SHALL issue no queue command, set error, and go to RESP.
REQ-022 ISSUE otherwise SHALL pulse gnt_o[idx] and the matching q_*_o for exactly one cycle, with q_kv_o = latched kv (KV_EMPTY for deq).
REQ-023 After an enq is issued, SHALL go to RESP next cycle with rsp_kv_o = KV_EMPTY.
REQ-024 After a deq/repl is issued, SHALL stay in WAIT for RD_LAT cycles, capture q_kv_i on the last WAIT cycle, then go to RESP.
REQ-025 RESP: SHALL pulse rsp_vld_o[idx] for one cycle, update the last-served pointer to idx, and return to IDLE.
REQ-026 Latency from IDLE accept cycle t SHALL be: command at t+1; enq/err response at t+2; deq/repl response at t+2+RD_LAT.
REQ-027 Requesters SHALL hold req_i/op_i/kv_i until rsp_vld_o; a deassertion mid-transaction SHALL be ignored and the transaction SHALL complete.
REQ-028 At most one transaction SHALL be outstanding; q_*_o SHALL never be mutually active.
REQ-029 Error responses SHALL also pulse gnt_o = 0 (no grant) and SHALL still advance the round-robin pointer.

Reset
REQ-030 On rst=1, SHALL asynchronously force state IDLE; gnt_o, rsp_vld_o, rsp_err_o, q_enq_o, q_deq_o, q_repl_o, busy_o = 0; rsp_kv_o, q_kv_o = KV_EMPTY.
REQ-031 Reset SHALL set the last-served pointer to NREQ-1, so requester 0 has first priority.
REQ-032 Reset asserted mid-transaction SHALL abandon it with no response pulse.

Configuration
REQ-033 With macro QQ_ARB_STATS_EN defined, SHALL add outputs stat_enq_o, stat_deq_o, stat_repl_o, stat_err_o (16 bits each): saturating counts of issued commands and errors, reset to 0.
REQ-034 Without QQ_ARB_STATS_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-035 Reset, then req_i=0001, op enq, kv=5 -> q_enq_o pulse at t+1 with q_kv_o=5; rsp_vld_o=0001, rsp_err_o=0 at t+2.
REQ-036 Queue holds {3,7}, RD_LAT=2, req_i=0010, op deq -> q_deq_o at t+1; rsp_vld_o=0010, rsp_kv_o=3 at t+4.
REQ-037 req_i=1111, all enq, queue not full -> grant order 0,1,2,3; four responses; no starvation.
REQ-038 q_empty_i=1, deq request from port 2 -> no q_deq_o; rsp_vld_o=0100, rsp_err_o=1, rsp_kv_o=KV_EMPTY at t+2.
REQ-039 rst pulsed during WAIT -> all outputs zero/KV_EMPTY immediately, no rsp_vld_o; next request from port 0 served first.
REQ-040 With QQ_ARB_STATS_EN: 3 enq, 1 deq, 1 error -> stat_enq_o=3, stat_deq_o=1, stat_repl_o=0, stat_err_o=1.
